// File: rtl/seq_detector_110110_overlap.sv
// Mealy detector for the serial pattern 1,1,0,1,1,0 with overlapping matches.
// detect is combinational from the current state and the bit on `in`.
module seq_detector_110110_overlap (
   input  logic clk,
   input  logic rst_n,
   input  logic in,
   output logic detect
);

   // Each state names the longest suffix of the stream that is a prefix of 110110
   typedef enum logic [2:0] {
      S0 = 3'd0,
      S1 = 3'd1,
      S2 = 3'd2,
      S3 = 3'd3,
      S4 = 3'd4,
      S5 = 3'd5
   } state_t;

   state_t state_r;
   state_t next_s;

   // State register with asynchronous return to S0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S0;
      end else begin
         state_r <= next_s;
      end
   end

   // Next-state and Mealy output; unused encodings fall back to S0
   always_comb begin
      next_s = S0;
      detect = 1'b0;
      case (state_r)
         S0: begin
            if (in) next_s = S1;
            else    next_s = S0;
         end
         S1: begin
            if (in) next_s = S2;
            else    next_s = S0;
         end
         S2: begin
            if (in) next_s = S2;
            else    next_s = S3;
         end
         S3: begin
            if (in) next_s = S4;
            else    next_s = S0;
         end
         S4: begin
            if (in) next_s = S5;
            else    next_s = S0;
         end
         S5: begin
            // On a match the trailing "110" seeds the next occurrence
            if (in) begin
               next_s = S2;
            end else begin
               next_s = S3;
               detect = 1'b1;
            end
         end
         default: begin
            next_s = S0;
            detect = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_seq_detector_110110_overlap.sv
// Bench for seq_detector_110110_overlap: directed literal sequences plus random
// stream, compared every cycle against a last-five-bits window model.
module tb_seq_detector_110110_overlap;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in = 1'b0;
   logic detect;

   int total = 0;
   int bad = 0;
   bit chk_en = 1'b0;

   // Model: bits received since reset, newest in bit 0
   logic [4:0] hist = 5'b00000;
   int cnt = 0;

   seq_detector_110110_overlap dut (
      .clk(clk),
      .rst_n(rst_n),
      .in(in),
      .detect(detect)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist <= 5'b00000;
         cnt <= 0;
      end else begin
         hist <= {hist[3:0], in};
         if (cnt < 5) cnt <= cnt + 1;
      end
   end

   // A match ends on the current bit when the five previous bits were 11011 and in is 0
   always @(negedge clk) begin
      logic expv;
      if (chk_en) begin
         expv = rst_n && (cnt >= 5) && (hist == 5'b11011) && (in == 1'b0);
         total++;
         if (detect !== expv) begin
            bad++;
            $display("FAIL model t=%0t detect=%b expected=%b", $time, detect, expv);
         end
      end
   end

   task automatic chk(input string name, input logic [2:0] act, input logic [2:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, act, expv);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      in = 1'b0;
      #1 chk("reset_detect", {2'b00, detect}, 3'd0);
      chk("reset_state", dut.state_r, 3'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
   endtask

   task automatic run_seq(input string name, input logic [19:0] bits,
                          input logic [19:0] expd, input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1 in = bits[n-1-i];
         @(negedge clk);
         chk(name, {2'b00, detect}, {2'b00, expd[n-1-i]});
      end
   endtask

   initial begin
      do_reset();
      chk_en = 1'b1;

      run_seq("basic", 20'b110110, 20'b000001, 6);
      @(posedge clk);
      #1 in = 1'b1;
      @(negedge clk);
      chk("after_detect", {2'b00, detect}, 3'd0);

      do_reset();
      run_seq("overlap", 20'b110110110, 20'b000001001, 9);

      do_reset();
      run_seq("lead1", 20'b1110110, 20'b0000001, 7);

      do_reset();
      run_seq("111path", 20'b1101110110, 20'b0000000001, 10);

      do_reset();
      run_seq("zeros", 20'h00000, 20'h00000, 20);
      do_reset();
      run_seq("ones", 20'hfffff, 20'h00000, 20);

      // Reset mid-pattern must discard the pending 11011
      do_reset();
      run_seq("pre_rst", 20'b11011, 20'b00000, 5);
      #2 rst_n = 1'b0;
      in = 1'b0;
      #1 chk("mid_rst_state", dut.state_r, 3'd0);
      chk("mid_rst_detect", {2'b00, detect}, 3'd0);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1 in = 1'b0;
      @(negedge clk);
      chk("post_rst", {2'b00, detect}, 3'd0);

      // Random stream biased toward ones, with occasional asynchronous resets
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #1 in = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
         if ($urandom_range(0, 199) == 0) begin
            #1 rst_n = 1'b0;
            #1 chk("rand_rst_state", dut.state_r, 3'd0);
            #1 rst_n = 1'b1;
         end
      end
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
